// File: rtl/ahb_sramc_pkg.sv
// Shared encodings for the AHB SRAM slave controller: AHB transfer, response
// and size codes, plus the controller state enum.
package ahb_sramc_pkg;

  // htrans
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // hresp
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // hsize
  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahb_be_gen.sv
// Byte-enable and legality generator for one AHB address phase.
// Ports:
//   addr_lo  - low byte-lane bits of haddr
//   hsize    - AHB transfer size
//   be       - byte enables: 2^hsize ones shifted to the addressed lane
//   size_ok  - hsize fits within the data bus
//   align_ok - address aligned to the transfer size
module ahb_be_gen
  import ahb_sramc_pkg::*;
#(
  parameter  int unsigned AHB_DATA_WIDTH = 32,
  localparam int unsigned NB             = AHB_DATA_WIDTH / 8,
  localparam int unsigned BL             = $clog2(NB)
) (
  input  logic [BL-1:0] addr_lo,
  input  logic [2:0]    hsize,
  output logic [NB-1:0] be,
  output logic          size_ok,
  output logic          align_ok
);

  // One extra bit so that the all-lanes mask (1 << NB) - 1 is representable.
  localparam int unsigned MW = NB + 1;
  localparam logic [2:0] MAX_SIZE = (AHB_DATA_WIDTH == 64) ? HSIZE_DWORD : HSIZE_WORD;

  logic [MW-1:0] nbytes;
  logic [MW-1:0] ones;

  always_comb begin
    size_ok  = (hsize <= MAX_SIZE);
    nbytes   = MW'(1) << hsize;
    ones     = MW'((MW'(1) << nbytes) - MW'(1));
    align_ok = ((addr_lo & BL'(nbytes - MW'(1))) == '0);
    be       = size_ok ? NB'(ones << addr_lo) : '0;
  end

endmodule

// File: rtl/ahb_sram_slave_ctrl.sv
// AHB slave front end converting AHB transfers into single-port synchronous
// SRAM accesses, with configurable read wait states and the two-cycle ERROR
// response for illegal transfers.
// Ports:
//   clock, reset           - bus clock, synchronous active-high reset
//   hsel..hready_in        - AHB slave inputs (hburst is informational only)
//   hrdata, hready_out,    - AHB slave outputs
//   hresp
//   mem_cs, mem_we, mem_be,- SRAM macro request; mem_rdata returns one cycle
//   mem_addr, mem_wdata,     after a read access
//   mem_rdata
// Build option: define AHB_SLV_PROT_CHECK_EN to reject user-mode writes into
// the top 1/8 of the region; otherwise hprot is ignored.
module ahb_sram_slave_ctrl
  import ahb_sramc_pkg::*;
#(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter int unsigned MEM_AW         = 13,
  parameter int unsigned RD_WAIT        = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        hsel,
  input  logic [AHB_ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]                  htrans,
  input  logic                        hwrite,
  input  logic [2:0]                  hsize,
  input  logic [2:0]                  hburst,
  input  logic [3:0]                  hprot,
  input  logic [AHB_DATA_WIDTH-1:0]   hwdata,
  input  logic                        hready_in,
  output logic [AHB_DATA_WIDTH-1:0]   hrdata,
  output logic                        hready_out,
  output logic [1:0]                  hresp,
  output logic                        mem_cs,
  output logic                        mem_we,
  output logic [AHB_DATA_WIDTH/8-1:0] mem_be,
  output logic [MEM_AW-1:0]           mem_addr,
  output logic [AHB_DATA_WIDTH-1:0]   mem_wdata,
  input  logic [AHB_DATA_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned NB      = AHB_DATA_WIDTH / 8;
  localparam int unsigned BL      = $clog2(NB);
  localparam int unsigned RGN_TOP = MEM_AW + BL;  // first byte-address bit outside the region

  state_e                    state;
  logic [1:0]                wait_cnt;
  logic [AHB_DATA_WIDTH-1:0] hrdata_q;

  logic              accept;
  logic              legal;
  logic              size_ok;
  logic              align_ok;
  logic              region_ok;
  logic              prot_ok;
  logic [NB-1:0]     be;
  logic [MEM_AW-1:0] word_addr;
  logic              unused_bits;

  ahb_be_gen #(
    .AHB_DATA_WIDTH(AHB_DATA_WIDTH)
  ) u_be_gen (
    .addr_lo (haddr[BL-1:0]),
    .hsize   (hsize),
    .be      (be),
    .size_ok (size_ok),
    .align_ok(align_ok)
  );

  // Address-phase decode
  assign accept    = hsel && hready_in && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  assign region_ok = (haddr[AHB_ADDR_WIDTH-1:RGN_TOP] == '0);
  assign word_addr = haddr[RGN_TOP-1:BL];

`ifdef AHB_SLV_PROT_CHECK_EN
  // User-mode writes may not touch the top eighth of the region.
  assign prot_ok     = !(hwrite && !hprot[1] && (word_addr[MEM_AW-1 -: 3] == 3'b111));
  assign unused_bits = ^{hburst, hprot[3:2], hprot[0]};
`else
  assign prot_ok     = 1'b1;
  assign unused_bits = ^{hburst, hprot};
`endif

  assign legal = size_ok && align_ok && region_ok && prot_ok;

  // Control FSM; all bus and memory outputs except the data paths are registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      hrdata_q   <= '0;
      hready_out <= 1'b1;
      hresp      <= HRESP_OKAY;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
    end else begin
      case (state)
        ST_RD_REQ: begin
          mem_cs <= 1'b0;
          if (RD_WAIT > 0) begin
            state    <= ST_RD_WAIT;
            wait_cnt <= 2'(RD_WAIT - 1);
          end else begin
            state      <= ST_RD_DATA;
            hready_out <= 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (wait_cnt == '0) begin
            state      <= ST_RD_DATA;
            hready_out <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_ERR1: begin
          state      <= ST_ERR2;
          hready_out <= 1'b1;
        end
        default: begin
          // IDLE, WR, RD_DATA, ERR2: hready_out is high, so a new address phase may complete.
          if (state == ST_RD_DATA) hrdata_q <= mem_rdata;
          if (!accept) begin
            state      <= ST_IDLE;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            hready_out <= 1'b1;
            hresp      <= HRESP_OKAY;
          end else if (!legal) begin
            state      <= ST_ERR1;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            hready_out <= 1'b0;
            hresp      <= HRESP_ERROR;
          end else begin
            state      <= hwrite ? ST_WR : ST_RD_REQ;
            mem_cs     <= 1'b1;
            mem_we     <= hwrite;
            mem_addr   <= word_addr;
            mem_be     <= be;
            hready_out <= hwrite;
            hresp      <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // hwdata only exists in the data phase, so it is steered straight to the SRAM while writing.
  assign mem_wdata = mem_we ? hwdata : '0;

  // SRAM data arrives in the same cycle it must be on the bus; forward it, then hold the copy.
  assign hrdata = (state == ST_RD_DATA) ? mem_rdata : hrdata_q;

endmodule

// File: tb/tb_ahb_sram_slave_ctrl.sv
// Self-checking bench for ahb_sram_slave_ctrl (RD_WAIT=2) with an SRAM macro
// stand-in and a byte-addressed reference memory.
module tb_ahb_sram_slave_ctrl;
  import ahb_sramc_pkg::*;

  localparam int unsigned AW           = 32;
  localparam int unsigned DW           = 32;
  localparam int unsigned MAW          = 13;
  localparam int unsigned RDW          = 2;
  localparam int unsigned NB           = DW / 8;
  localparam int unsigned REGION_BYTES = (1 << MAW) * NB;
  localparam int          RD_LAT       = 1 + RDW;

  logic          clock = 1'b0;
  logic          reset;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic [DW-1:0] hwdata;
  wire           hready_in;
  logic [DW-1:0] hrdata;
  logic          hready_out;
  logic [1:0]    hresp;
  logic          mem_cs;
  logic          mem_we;
  logic [NB-1:0] mem_be;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sram [0:(1<<MAW)-1] = '{default: '0};
  logic [7:0]    ref_mem [0:REGION_BYTES-1] = '{default: 8'h00};
  int unsigned   n_mem_wr = 0;
  logic [DW-1:0] last_rd = '0;

  always #5 clock = ~clock;

  assign hready_in = hready_out;  // only slave on the bus

  ahb_sram_slave_ctrl #(
    .AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW), .MEM_AW(MAW), .RD_WAIT(RDW)
  ) dut (
    .clock(clock), .reset(reset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready_in(hready_in), .hrdata(hrdata), .hready_out(hready_out), .hresp(hresp),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // SRAM macro stand-in: byte-masked write, registered read
  always @(posedge clock) begin
    if (mem_cs) begin
      if (mem_we) begin
        for (int b = 0; b < NB; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        n_mem_wr <= n_mem_wr + 1;
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic bit exp_legal(input logic [31:0] a, input logic [2:0] sz,
                                   input logic wr, input logic [3:0] prot);
    int unsigned nbytes;
    if (sz > 3'd2) return 1'b0;
    nbytes = 32'd1 << sz;
    if ((a % nbytes) != 0) return 1'b0;
    if (a >= REGION_BYTES) return 1'b0;
`ifdef AHB_SLV_PROT_CHECK_EN
    if (wr && !prot[1] && (a >= (REGION_BYTES / 8) * 7)) return 1'b0;
`else
    if (wr && prot[1] && 1'b0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [NB-1:0] exp_be(input logic [31:0] a, input logic [2:0] sz);
    int unsigned ones;
    ones = (32'd1 << (32'd1 << sz)) - 1;
    return NB'(ones << (a % NB));
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [2:0] sz, input logic [DW-1:0] d);
    int unsigned lane;
    for (int unsigned k = 0; k < (32'd1 << sz); k++) begin
      lane = (a % NB) + k;
      ref_mem[a + k] = d[8*lane +: 8];
    end
  endfunction

  function automatic logic [DW-1:0] ref_word(input logic [31:0] a);
    logic [DW-1:0] w;
    int unsigned base;
    base = a - (a % NB);
    for (int unsigned k = 0; k < NB; k++) w[8*k +: 8] = ref_mem[base + k];
    return w;
  endfunction

  // ---------------- bus driver (returns observations only) ----------------
  // Entered and left at posedge+1.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [3:0] prot, input logic [DW-1:0] wd,
                      output int waits, output bit err_wait_ok, output logic [1:0] resp,
                      output logic [DW-1:0] rd, output bit saw_cs,
                      output logic dcs, output logic dwe, output logic [MAW-1:0] daddr,
                      output logic [NB-1:0] dbe, output logic [DW-1:0] dwd, output bit tmo);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = a; hwrite = wr; hsize = sz; hprot = prot; hburst = 3'd0;
    @(posedge clock); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; haddr = $urandom; hwrite = 1'($urandom); hwdata = wd;
    #1;
    dcs = mem_cs; dwe = mem_we; daddr = mem_addr; dbe = mem_be; dwd = mem_wdata;
    waits = 0; err_wait_ok = 1'b1; saw_cs = 1'b0; tmo = 1'b0;
    while (hready_out !== 1'b1) begin
      if (mem_cs === 1'b1) saw_cs = 1'b1;
      if (hresp !== HRESP_ERROR) err_wait_ok = 1'b0;
      waits++;
      if (waits > 20) begin tmo = 1'b1; break; end
      @(posedge clock); #2;
    end
    if (mem_cs === 1'b1) saw_cs = 1'b1;
    resp = hresp; rd = hrdata;
    @(posedge clock); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; hwdata = '0;
    repeat (3) @(posedge clock);
    #2;
    checks++; if (hready_out !== 1'b1) begin errors++; $display("FAIL rst_hready: got %b expected 1", hready_out); end
    checks++; if (hresp !== HRESP_OKAY) begin errors++; $display("FAIL rst_hresp: got %b expected 00", hresp); end
    checks++; if (hrdata !== '0) begin errors++; $display("FAIL rst_hrdata: got %h expected 0", hrdata); end
    checks++; if ({mem_cs, mem_we} !== 2'b00) begin errors++; $display("FAIL rst_cs_we: got %b expected 00", {mem_cs, mem_we}); end
    checks++; if (mem_be !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL rst_mem: got be=%h addr=%h wdata=%h expected 0", mem_be, mem_addr, mem_wdata); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic check_xfer(input string name, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                            input logic [3:0] prot, input logic [DW-1:0] wd);
    int waits; bit ewok; logic [1:0] resp; logic [DW-1:0] rd; bit scs; bit tmo;
    logic dcs, dwe; logic [MAW-1:0] daddr; logic [NB-1:0] dbe; logic [DW-1:0] dwd;
    bit legal;
    legal = exp_legal(a, sz, wr, prot);
    xfer(wr, a, sz, prot, wd, waits, ewok, resp, rd, scs, dcs, dwe, daddr, dbe, dwd, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL %s_timeout: hready_out stuck low, expected release", name); end
    if (!legal) begin
      checks++; if (waits !== 1 || !ewok) begin errors++; $display("FAIL %s_err1: got waits=%0d err_in_wait=%b expected 1/1", name, waits, ewok); end
      checks++; if (resp !== HRESP_ERROR) begin errors++; $display("FAIL %s_err2: got hresp=%b expected 01", name, resp); end
      checks++; if (scs) begin errors++; $display("FAIL %s_err_cs: got mem_cs=1 expected 0", name); end
      checks++; if (rd !== last_rd) begin errors++; $display("FAIL %s_err_hold: got hrdata=%h expected %h", name, rd, last_rd); end
    end else if (wr) begin
      checks++; if (waits !== 0 || resp !== HRESP_OKAY) begin errors++; $display("FAIL %s_wr_resp: got waits=%0d hresp=%b expected 0/00", name, waits, resp); end
      checks++; if ({dcs, dwe} !== 2'b11 || daddr !== MAW'(a >> 2)) begin errors++; $display("FAIL %s_wr_mem: got cs/we=%b addr=%h expected 11/%h", name, {dcs, dwe}, daddr, MAW'(a >> 2)); end
      checks++; if (dbe !== exp_be(a, sz) || dwd !== wd) begin errors++; $display("FAIL %s_wr_be: got be=%b wdata=%h expected %b/%h", name, dbe, dwd, exp_be(a, sz), wd); end
      checks++; if (rd !== last_rd) begin errors++; $display("FAIL %s_wr_hold: got hrdata=%h expected %h", name, rd, last_rd); end
      ref_write(a, sz, wd);
    end else begin
      checks++; if (waits !== RD_LAT || resp !== HRESP_OKAY) begin errors++; $display("FAIL %s_rd_lat: got waits=%0d hresp=%b expected %0d/00", name, waits, resp, RD_LAT); end
      checks++; if ({dcs, dwe} !== 2'b10 || daddr !== MAW'(a >> 2)) begin errors++; $display("FAIL %s_rd_mem: got cs/we=%b addr=%h expected 10/%h", name, {dcs, dwe}, daddr, MAW'(a >> 2)); end
      checks++; if (rd !== ref_word(a)) begin errors++; $display("FAIL %s_rd_data: got %h expected %h", name, rd, ref_word(a)); end
      last_rd = ref_word(a);
    end
  endtask

  task automatic test_directed();
    check_xfer("word_wr",  1'b1, 32'h10,        3'd2, 4'b0011, 32'hA5A5_1234);
    check_xfer("word_rd",  1'b0, 32'h10,        3'd2, 4'b0011, 32'h0);
    check_xfer("byte_wr",  1'b1, 32'h13,        3'd0, 4'b0011, 32'hDE00_0000);
    check_xfer("byte_rd",  1'b0, 32'h10,        3'd2, 4'b0011, 32'h0);
    check_xfer("half_mis", 1'b1, 32'h11,        3'd1, 4'b0011, 32'h1234_5678);
    check_xfer("out_rgn",  1'b0, 32'h0001_0000, 3'd2, 4'b0011, 32'h0);
    check_xfer("big_size", 1'b0, 32'h20,        3'd3, 4'b0011, 32'h0);
  endtask

  task automatic test_random();
    logic wr; logic [2:0] sz; logic [31:0] a; logic [3:0] prot;
    for (int i = 0; i < 150; i++) begin
      wr   = 1'($urandom_range(0, 1));
      sz   = 3'($urandom_range(0, 4));
      prot = 4'($urandom);
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = $urandom_range(0, REGION_BYTES - 1);
        2:       a = $urandom_range(0, 255);
        default: a = $urandom_range(0, 127) & ~((32'd1 << sz) - 1);
      endcase
      check_xfer("rand", wr, a, sz, prot, $urandom);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d [4];
    int unsigned wr0;
    int waits;
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    wr0 = n_mem_wr;
    // INCR4 write burst 0x40..0x4C with one BUSY after the second beat
    hsel = 1'b1; hwrite = 1'b1; hsize = 3'd2; hburst = 3'b011; hprot = 4'b0011;
    htrans = HTRANS_NONSEQ; haddr = 32'h40;
    @(posedge clock); #1;
    hwdata = d[0]; htrans = HTRANS_SEQ; haddr = 32'h44; #1;
    checks++; if ({mem_cs, mem_we, hready_out} !== 3'b111 || mem_addr !== 13'h10 || mem_wdata !== d[0]) begin errors++; $display("FAIL b2b_beat0: got cs/we/rdy=%b addr=%h wdata=%h expected 111/010/%h", {mem_cs, mem_we, hready_out}, mem_addr, mem_wdata, d[0]); end
    @(posedge clock); #1;
    hwdata = d[1]; htrans = HTRANS_BUSY; haddr = 32'h48; #1;
    checks++; if ({mem_cs, mem_we} !== 2'b11 || mem_addr !== 13'h11 || mem_wdata !== d[1]) begin errors++; $display("FAIL b2b_beat1: got cs/we=%b addr=%h wdata=%h expected 11/011/%h", {mem_cs, mem_we}, mem_addr, mem_wdata, d[1]); end
    @(posedge clock); #1;
    hwdata = $urandom; htrans = HTRANS_SEQ; haddr = 32'h48; #1;
    checks++; if (mem_cs !== 1'b0 || hready_out !== 1'b1 || hresp !== HRESP_OKAY) begin errors++; $display("FAIL b2b_busy: got cs=%b rdy=%b hresp=%b expected 0/1/00", mem_cs, hready_out, hresp); end
    @(posedge clock); #1;
    hwdata = d[2]; htrans = HTRANS_SEQ; haddr = 32'h4C; #1;
    checks++; if (mem_cs !== 1'b1 || mem_addr !== 13'h12 || mem_wdata !== d[2]) begin errors++; $display("FAIL b2b_beat2: got cs=%b addr=%h wdata=%h expected 1/012/%h", mem_cs, mem_addr, mem_wdata, d[2]); end
    @(posedge clock); #1;
    hwdata = d[3]; htrans = HTRANS_IDLE; hsel = 1'b0; #1;
    checks++; if (mem_cs !== 1'b1 || mem_addr !== 13'h13 || mem_wdata !== d[3]) begin errors++; $display("FAIL b2b_beat3: got cs=%b addr=%h wdata=%h expected 1/013/%h", mem_cs, mem_addr, mem_wdata, d[3]); end
    @(posedge clock); #1;
    checks++; if (n_mem_wr - wr0 !== 4) begin errors++; $display("FAIL b2b_count: got %0d writes expected 4", n_mem_wr - wr0); end
    for (int i = 0; i < 4; i++) ref_write(32'h40 + 4 * i, 3'd2, d[i]);
    // write immediately followed by a read of the same word
    d[0] = $urandom;
    hsel = 1'b1; hwrite = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h80; hburst = 3'd0;
    @(posedge clock); #1;
    hwdata = d[0]; hwrite = 1'b0; haddr = 32'h80;
    @(posedge clock); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; #1;
    waits = 0;
    while (hready_out !== 1'b1 && waits <= 20) begin waits++; @(posedge clock); #2; end
    ref_write(32'h80, 3'd2, d[0]);
    checks++; if (waits !== RD_LAT) begin errors++; $display("FAIL wr_rd_lat: got %0d wait cycles expected %0d", waits, RD_LAT); end
    checks++; if (hrdata !== ref_word(32'h80) || hresp !== HRESP_OKAY) begin errors++; $display("FAIL wr_rd_data: got %h/%b expected %h/00", hrdata, hresp, ref_word(32'h80)); end
    last_rd = ref_word(32'h80);
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) check_xfer("burst_rb", 1'b0, 32'h40 + 4 * i, 3'd2, 4'b0011, 32'h0);
  endtask

  task automatic test_reset_mid_read();
    hsel = 1'b1; hwrite = 1'b0; htrans = HTRANS_NONSEQ; haddr = 32'h44; hsize = 3'd2;
    @(posedge clock); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE;
    @(posedge clock); #1;
    checks++; if (hready_out !== 1'b0) begin errors++; $display("FAIL midrst_wait: got hready_out=%b expected 0", hready_out); end
    reset = 1'b1;
    @(posedge clock); #2;
    checks++; if (hready_out !== 1'b1 || hresp !== HRESP_OKAY) begin errors++; $display("FAIL midrst_ready: got rdy=%b hresp=%b expected 1/00", hready_out, hresp); end
    checks++; if (hrdata !== '0 || mem_cs !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL midrst_out: got hrdata=%h cs=%b we=%b expected 0/0/0", hrdata, mem_cs, mem_we); end
    reset = 1'b0;
    last_rd = '0;
    @(posedge clock); #1;
    check_xfer("post_rst", 1'b0, 32'h44, 3'd2, 4'b0011, 32'h0);
  endtask

  task automatic test_prot();
    int unsigned wr0;
    wr0 = n_mem_wr;
    check_xfer("prot_user", 1'b1, 32'h7C00, 3'd2, 4'b0001, 32'h1111_2222);
`ifdef AHB_SLV_PROT_CHECK_EN
    checks++; if (n_mem_wr !== wr0) begin errors++; $display("FAIL prot_user_nowr: got %0d writes expected 0", n_mem_wr - wr0); end
`else
    checks++; if (n_mem_wr !== wr0 + 1) begin errors++; $display("FAIL prot_user_wr: got %0d writes expected 1", n_mem_wr - wr0); end
`endif
    check_xfer("prot_priv", 1'b1, 32'h7C00, 3'd2, 4'b0011, 32'h3333_4444);
    check_xfer("prot_rd",   1'b0, 32'h7C00, 3'd2, 4'b0001, 32'h0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_read();
    test_prot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
